// File: rtl/dmem_arbiter_if.sv
// Bundle between two requesters (core port 0, debug/DMA port 1), the arbiter and a single-port data memory.
// Requesters drive req/we/addr/wdata and the memory drives mem_data_out; the arbiter drives everything else.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        gnt;
  logic [1:0]        rvalid;
  logic [1:0]        err;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              mem_wr_en;
  logic              mem_r_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, mem_data_out,
    input  gnt, rvalid, err, rdata, busy, mem_wr_en, mem_r_en, mem_addr, mem_data_in
  );

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, mem_data_out,
    output gnt, rvalid, err, rdata, busy, mem_wr_en, mem_r_en, mem_addr, mem_data_in
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving two requesters access to one data memory; gnt one cycle and rvalid two cycles after req is sampled.
// One access per two cycles; requesters hold req until gnt, and req is ignored while an access is in flight.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              take;
  logic              win;
  logic              owner;
  logic              last;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              aligned;

  assign aligned = (lat_addr[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.req != 2'b00) begin
          state_nxt = ACCESS;
          take      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACCESS:  state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // On a conflict the port that did not win last time goes first.
  always_comb begin
    win = 1'b0;
    case (bus.req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last;
      default: win = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= 1'b0;
      last      <= 1'b1;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      if (take) begin
        owner     <= win;
        last      <= win;
        lat_addr  <= win ? bus.addr1 : bus.addr0;
        lat_we    <= bus.we[win];
        lat_wdata <= win ? bus.wdata1 : bus.wdata0;
      end
      // A misaligned access of either kind reports zero data alongside err.
      if (state == ACCESS) begin
        if (!aligned) begin
          rdata_q <= '0;
        end else if (!lat_we) begin
          rdata_q <= bus.mem_data_out;
        end
      end
    end
  end

  always_comb begin
    bus.gnt       = 2'b00;
    bus.rvalid    = 2'b00;
    bus.err       = 2'b00;
    bus.mem_wr_en = 1'b0;
    bus.mem_r_en  = 1'b0;
    if (state == ACCESS) begin
      bus.gnt[owner] = 1'b1;
      bus.mem_wr_en  = lat_we & aligned;
      bus.mem_r_en   = ~lat_we & aligned;
    end
    // A reset landing on the completion cycle aborts the transaction.
    if (state == DONE && !rst) begin
      bus.rvalid[owner] = 1'b1;
      bus.err[owner]    = ~aligned;
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.mem_addr    = lat_addr >> 2;
  assign bus.mem_data_in = lat_wdata;
  assign bus.rdata       = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, contention and reset corner cases, then random traffic against a transaction model.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Memory environment: unwritten words read back a fixed per-index pattern.
  logic [DW-1:0] mem [0:63];
  logic [63:0]   written = '0;

  function automatic logic [DW-1:0] init_word(input int unsigned i);
    if (i == 3) return 32'h00AB_CD00;
    return (i * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      mem[bus.mem_addr[5:0]]     <= bus.mem_data_in;
      written[bus.mem_addr[5:0]] <= 1'b1;
    end
  end

  assign bus.mem_data_out = written[bus.mem_addr[5:0]] ? mem[bus.mem_addr[5:0]]
                                                       : init_word({26'd0, bus.mem_addr[5:0]});

  function automatic logic [1:0] oh(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    bus.req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        port;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input vec_t v, input int idx);
    logic [1:0] o;
    logic       al;
    o  = oh(v.port);
    al = (v.addr[1:0] == 2'b00);
    @(negedge clk);
    chk($sformatf("v%0d idle_busy", idx), 64'(bus.busy), 64'(1'b0));
    bus.req = o;
    bus.we  = v.wr ? o : 2'b00;
    if (v.port) begin
      bus.addr1  = v.addr;
      bus.wdata1 = v.wdata;
    end else begin
      bus.addr0  = v.addr;
      bus.wdata0 = v.wdata;
    end
    @(negedge clk);
    chk($sformatf("v%0d gnt", idx), 64'(bus.gnt), 64'(o));
    chk($sformatf("v%0d mem_wr_en", idx), 64'(bus.mem_wr_en), 64'(v.wr & al));
    chk($sformatf("v%0d mem_r_en", idx), 64'(bus.mem_r_en), 64'(~v.wr & al));
    if (al) chk($sformatf("v%0d mem_addr", idx), 64'(bus.mem_addr), 64'(v.addr >> 2));
    if (al && v.wr) chk($sformatf("v%0d mem_data_in", idx), 64'(bus.mem_data_in), 64'(v.wdata));
    bus.req = 2'b00;
    @(negedge clk);
    chk($sformatf("v%0d rvalid", idx), 64'(bus.rvalid), 64'(o));
    chk($sformatf("v%0d err", idx), 64'(bus.err), 64'(v.exp_err ? o : 2'b00));
    chk($sformatf("v%0d rdata", idx), 64'(bus.rdata), 64'(v.exp_rdata));
    chk($sformatf("v%0d done_gnt", idx), 64'(bus.gnt), 64'(2'b00));
    chk($sformatf("v%0d done_en", idx), 64'({bus.mem_wr_en, bus.mem_r_en}), 64'(2'b00));
  endtask

  // Transaction-level reference model state
  logic [31:0] ref_mem [64];
  bit          ref_wr  [64];
  bit          pend [2];
  bit          won  [2];
  logic        p_we   [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wd   [2];
  logic        a_vld, a_port, a_we, d_vld, d_port, d_err, m_last, accept_ok, w, gen;
  logic [31:0] a_addr, a_wd, d_rdata, m_rdata;
  logic [1:0]  cg [8];
  logic [1:0]  cr [8];

  function automatic logic [31:0] ref_rd(input int unsigned i);
    return ref_wr[i] ? ref_mem[i] : init_word(i);
  endfunction

  initial begin
    rst = 1'b1;
    bus.req = 2'b00; bus.we = 2'b00;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    for (int i = 0; i < 64; i++) ref_wr[i] = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 32'h0C, 32'h0,         32'h00AB_CD00, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h00AB_CD00, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'h11, 32'h1234_5678, 32'h0,         1'b1};
    vecs[4] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h06, 32'h0,         32'h0,         1'b1};
    vecs[6] = '{1'b1, 1'b0, 32'h0C, 32'h0,         32'h00AB_CD00, 1'b0};

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst gnt", 64'(bus.gnt), 64'(2'b00));
    chk("rst rvalid", 64'(bus.rvalid), 64'(2'b00));
    chk("rst err", 64'(bus.err), 64'(2'b00));
    chk("rst busy", 64'(bus.busy), 64'(1'b0));
    chk("rst mem_en", 64'({bus.mem_wr_en, bus.mem_r_en}), 64'(2'b00));
    chk("rst mem_addr", 64'(bus.mem_addr), 64'(0));
    chk("rst mem_data_in", 64'(bus.mem_data_in), 64'(0));
    chk("rst rdata", 64'(bus.rdata), 64'(0));
    rst = 1'b0;

    // A request withdrawn before any rising edge is never served
    @(negedge clk);
    bus.req = 2'b01; bus.we = 2'b00; bus.addr0 = 32'h0C;
    #2 bus.req = 2'b00;
    @(negedge clk);
    chk("drop busy", 64'(bus.busy), 64'(1'b0));
    chk("drop gnt", 64'(bus.gnt), 64'(2'b00));
    @(negedge clk);
    chk("drop rvalid", 64'(bus.rvalid), 64'(2'b00));

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Continuous contention from reset alternates 01,10 with rvalid one cycle behind
    cg = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    cr = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    do_reset();
    bus.req = 2'b11; bus.we = 2'b00; bus.addr0 = 32'h0C; bus.addr1 = 32'h10;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("cont%0d gnt", k), 64'(bus.gnt), 64'(cg[k]));
      chk($sformatf("cont%0d rvalid", k), 64'(bus.rvalid), 64'(cr[k]));
    end
    bus.req = 2'b00;

    // Reset during the ACCESS cycle of a write
    @(negedge clk);
    bus.req = 2'b10; bus.we = 2'b10; bus.addr1 = 32'h40; bus.wdata1 = 32'hCAFE_F00D;
    @(negedge clk);
    chk("midrst gnt", 64'(bus.gnt), 64'(2'b10));
    chk("midrst wr_en", 64'(bus.mem_wr_en), 64'(1'b1));
    chk("midrst mem_addr", 64'(bus.mem_addr), 64'(16));
    rst = 1'b1; bus.req = 2'b00;
    @(negedge clk);
    chk("midrst rvalid", 64'(bus.rvalid), 64'(2'b00));
    chk("midrst err", 64'(bus.err), 64'(2'b00));
    chk("midrst busy", 64'(bus.busy), 64'(1'b0));
    chk("midrst wr_en_after", 64'(bus.mem_wr_en), 64'(1'b0));
    rst = 1'b0;
    bus.req = 2'b11; bus.we = 2'b00; bus.addr0 = 32'h0C; bus.addr1 = 32'h10;
    @(negedge clk);
    chk("midrst conflict gnt", 64'(bus.gnt), 64'(2'b01));
    bus.req = 2'b00;
    @(negedge clk);
    chk("midrst conflict rvalid", 64'(bus.rvalid), 64'(2'b01));

    // Random traffic against the transaction model (memory words 32..39)
    do_reset();
    m_last = 1'b1; m_rdata = '0; a_vld = 1'b0; d_vld = 1'b0;
    a_port = 1'b0; a_we = 1'b0; a_addr = '0; a_wd = '0; d_port = 1'b0; d_err = 1'b0; d_rdata = '0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; won[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = '0; p_wd[p] = '0;
    end
    for (int cyc = 0; cyc < 620; cyc++) begin
      gen = (cyc < 600);
      @(negedge clk);
      chk("rnd gnt", 64'(bus.gnt), 64'(a_vld ? oh(a_port) : 2'b00));
      chk("rnd mem_wr_en", 64'(bus.mem_wr_en), 64'(a_vld && a_we && a_addr[1:0] == 2'b00));
      chk("rnd mem_r_en", 64'(bus.mem_r_en), 64'(a_vld && !a_we && a_addr[1:0] == 2'b00));
      if (a_vld && a_addr[1:0] == 2'b00) begin
        chk("rnd mem_addr", 64'(bus.mem_addr), 64'(a_addr >> 2));
        if (a_we) chk("rnd mem_data_in", 64'(bus.mem_data_in), 64'(a_wd));
      end
      chk("rnd rvalid", 64'(bus.rvalid), 64'(d_vld ? oh(d_port) : 2'b00));
      chk("rnd err", 64'(bus.err), 64'(d_vld && d_err ? oh(d_port) : 2'b00));
      if (d_vld) chk("rnd rdata", 64'(bus.rdata), 64'(d_rdata));

      // The access granted last cycle completes now
      d_vld = a_vld;
      if (a_vld) begin
        d_port = a_port;
        d_err  = (a_addr[1:0] != 2'b00);
        if (d_err) m_rdata = '0;
        else if (a_we) begin
          ref_mem[a_addr[7:2]] = a_wd;
          ref_wr[a_addr[7:2]]  = 1'b1;
        end else m_rdata = ref_rd({26'd0, a_addr[7:2]});
        d_rdata = m_rdata;
      end
      accept_ok = !a_vld;

      for (int p = 0; p < 2; p++) begin
        if (won[p]) begin
          pend[p] = 1'b0;
          won[p]  = 1'b0;
        end
        if (gen && !pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p]   = 1'b1;
          p_we[p]   = 1'($urandom_range(0, 1));
          p_addr[p] = (32'd32 + $urandom_range(0, 7)) * 4 +
                      (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
          p_wd[p]   = $urandom;
        end
      end
      bus.req    = {pend[1], pend[0]};
      bus.we     = {p_we[1], p_we[0]};
      bus.addr0  = p_addr[0];
      bus.addr1  = p_addr[1];
      bus.wdata0 = p_wd[0];
      bus.wdata1 = p_wd[1];

      a_vld = 1'b0;
      if (accept_ok && (pend[0] || pend[1])) begin
        w      = (pend[0] && pend[1]) ? ~m_last : pend[1];
        m_last = w;
        won[w] = 1'b1;
        a_vld  = 1'b1;
        a_port = w;
        a_we   = p_we[w];
        a_addr = p_addr[w];
        a_wd   = p_wd[w];
      end
    end
    chk("rnd drained busy", 64'(bus.busy), 64'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of both requesters and the memory port.
REQ-002 Parameter DATA_W, default 32, data width of write data, read data and the memory word.
REQ-003 The block SHALL have one clock, clk; reset is synchronous and active-high, named rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req  input  2  per-requester access request; bit 0 is the core load/store port, bit 1 is the debug/DMA port.
REQ-007 we  input  2  per-requester write select; 1 means write, 0 means read.
REQ-008 addr0, addr1  input  ADDR_W each  byte address per requester.
REQ-009 wdata0, wdata1  input  DATA_W each  write data per requester.
REQ-010 gnt  output  2  one-hot grant pulse.
REQ-011 rvalid  output  2  one-hot completion pulse.
REQ-012 err  output  2  one-hot misalignment error pulse, coincident with rvalid.
REQ-013 rdata  output  DATA_W  read data, shared by both requesters and qualified by rvalid.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 mem_wr_en, mem_r_en  output  1 each  memory write enable and read enable.
REQ-016 mem_addr  output  ADDR_W  word index into memory, equal to the latched byte address >> 2.
REQ-017 mem_data_in  output  DATA_W  memory write data.
REQ-018 mem_data_out  input  DATA_W  combinational read data from memory.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS and DONE, encoded in a registered state variable.
REQ-020 In IDLE or DONE, if req != 0 at a rising edge: select a winner, latch its addr/we/wdata and owner index, go to ACCESS; otherwise go to IDLE.
REQ-021 Arbitration SHALL be round-robin: single request wins outright; if both request, the port other than the last granted one wins, and last-granted is updated on every grant.
REQ-022 In ACCESS, gnt[owner] SHALL be 1 for exactly that cycle; ACCESS always goes to DONE on the next edge.
REQ-023 Aligned write (latched addr[1:0]==0) in ACCESS: mem_wr_en=1, mem_addr=addr>>2, mem_data_in=latched wdata, for exactly one cycle.
REQ-024 Aligned read in ACCESS: mem_r_en=1, mem_addr=addr>>2; mem_data_out SHALL be captured into the rdata register at the ACCESS->DONE edge.
REQ-025 Misaligned access (addr[1:0]!=0) SHALL assert neither mem_wr_en nor mem_r_en; in DONE, err[owner]=1 and rdata=0.
REQ-026 In DONE, rvalid[owner]=1 for exactly one cycle for both reads and writes; rdata holds its value until the next read capture.
REQ-027 Latency: req sampled at edge N gives gnt in cycle N+1 and rvalid in cycle N+2; back-to-back throughput is one access per 2 cycles via DONE->ACCESS.
REQ-028 Outside ACCESS, mem_wr_en=mem_r_en=0; mem_addr and mem_data_in SHALL hold their last latched values.
REQ-029 Requesters SHALL hold req until gnt; the block SHALL sample req only in IDLE/DONE and ignore it in ACCESS.
REQ-030 A req dropped before being sampled SHALL produce no access.
REQ-031 gnt, rvalid and err SHALL each have at most one bit set, and never for both ports.

Reset
REQ-032 rst=1 at a rising edge SHALL force: state=IDLE; last-granted=port 1 (port 0 wins the first conflict); gnt=rvalid=err=0; busy=0; mem_wr_en=mem_r_en=0; mem_addr=0; mem_data_in=0; rdata=0.
REQ-033 rst asserted in ACCESS or DONE SHALL abort the transaction: no rvalid or err is issued, and any write enable ends in the reset cycle.

Verification
REQ-034 Single read: port 0 reads addr0=0x0C with mem word 3=0x00ABCD00 -> gnt=01 at N+1 with mem_r_en=1 and mem_addr=3; rvalid=01 at N+2 with rdata=0x00ABCD00.
REQ-035 Write then read: port 1 writes 0xDEADBEEF to 0x10, then reads 0x10 -> mem_wr_en pulse with mem_addr=4; the later read returns 0xDEADBEEF.
REQ-036 Contention: both ports request continuously from reset -> grants alternate 01, 10, 01, 10, with rvalid following each grant by 1 cycle.
REQ-037 Misaligned: port 0 reads 0x06 -> no mem_r_en; err=01, rvalid=01, rdata=0.
REQ-038 Reset mid-op: rst raised in the ACCESS cycle of a write -> no rvalid; next cycle state=IDLE and busy=0; a following conflict is granted to port 0.
